// File: rtl/pic_sequencer_pkg.sv
// Shared definitions for the picture-index sequencer: slideshow mode codes,
// default picture count and a counter-width helper.
package pic_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_FWD    = 2'b01,
        MODE_REV    = 2'b10,
        MODE_PING   = 2'b11
    } mode_e;

    localparam int DEF_TOTAL_PIC = 13;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pic_sequencer_if.sv
// Button/mode inputs and picture-index outputs of the sequencer, bundled as one bus.
interface pic_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             btn_next;
    logic             btn_prev;
    pic_pkg::mode_e   mode;
    logic             pause;
    logic [IDX_W-1:0] index;
    logic             step;
    logic             wrap;
    logic             dir;

    modport master (
        output btn_next, btn_prev, mode, pause,
        input  index, step, wrap, dir
    );

    modport slave (
        input  btn_next, btn_prev, mode, pause,
        output index, step, wrap, dir
    );
endinterface

// File: rtl/pic_sequencer_btn_repeat.sv
// Edge detect plus hold-to-repeat for one debounced button; fire_o is a
// one-cycle request that the top level turns into an index step.
module btn_repeat
    import pic_pkg::*;
#(
    parameter int HOLD_CYC = 12500000,
    parameter int REP_CYC  = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic block_i,
    output logic fire_o
);
    localparam int HOLD_W = clog2_min1(HOLD_CYC);
    localparam int REP_W  = clog2_min1(REP_CYC);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REP_CYC - 1);

    logic              btn_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;

    // Once the hold count saturates, the repeat counter fires on every wrap through zero.
    always_comb begin
        hold_d = '0;
        rep_d  = '0;
        fire_o = 1'b0;
        if (btn_i && !block_i) begin
            if (!btn_q) begin
                fire_o = 1'b1;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end else begin
                hold_d = hold_q;
                fire_o = (rep_q == '0);
                rep_d  = (rep_q == REP_MAX) ? '0 : rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q  <= 1'b0;
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            btn_q  <= btn_i;
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
endmodule

// File: rtl/pic_sequencer.sv
// Picture-index sequencer: button stepping with hold-repeat, timed slideshow
// (forward, reverse, ping-pong) and registered step/wrap strobes.
module pic_sequencer
    import pic_pkg::*;
#(
    parameter int TOTAL_PIC   = DEF_TOTAL_PIC,
    parameter int IDX_W       = 4,
    parameter int AUTO_PERIOD = 16777216,
    parameter int HOLD_CYC    = 12500000,
    parameter int REP_CYC     = 5000000
) (
    input  logic           vgaclk,
    input  logic           rst,
    pic_sequencer_if.slave bus
);
    localparam int T_W = clog2_min1(AUTO_PERIOD);
    localparam logic [T_W-1:0]   T_MAX = T_W'(AUTO_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(TOTAL_PIC - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [T_W-1:0]   timer_q, timer_d;
    logic             dir_q, dir_d, step_q, step_d, wrap_q, wrap_d;
    mode_e            mode_q;
    logic             both, fire_next, fire_prev, btn_fire, auto_fire, mode_chg;
    logic             go_up, go_dn;

    assign both = bus.btn_next & bus.btn_prev;

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_next (
        .clk(vgaclk), .rst(rst), .btn_i(bus.btn_next), .block_i(both), .fire_o(fire_next)
    );

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_prev (
        .clk(vgaclk), .rst(rst), .btn_i(bus.btn_prev), .block_i(both), .fire_o(fire_prev)
    );

    assign btn_fire = fire_next | fire_prev;
    assign mode_chg = (bus.mode != mode_q);

    // A button step restarts the period, and also swallows a coincident terminal count.
    always_comb begin
        timer_d   = timer_q;
        auto_fire = 1'b0;
        if (mode_chg || btn_fire || bus.mode == MODE_MANUAL) begin
            timer_d = '0;
        end else if (!bus.pause) begin
            if (timer_q == T_MAX) begin
                timer_d   = '0;
                auto_fire = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        go_up  = 1'b0;
        go_dn  = 1'b0;
        if (fire_next) begin
            go_up = 1'b1;
        end else if (fire_prev) begin
            go_dn = 1'b1;
        end else if (auto_fire) begin
            case (bus.mode)
                MODE_FWD: go_up = 1'b1;
                MODE_REV: go_dn = 1'b1;
                MODE_PING: begin
                    // With a single picture the turn-around still strobes wrap but nothing moves.
                    if (dir_q && idx_q == LAST) begin
                        wrap_d = 1'b1;
                        if (TOTAL_PIC > 1) begin
                            dir_d = 1'b0;
                            go_dn = 1'b1;
                        end
                    end else if (!dir_q && idx_q == '0) begin
                        wrap_d = 1'b1;
                        if (TOTAL_PIC > 1) begin
                            dir_d = 1'b1;
                            go_up = 1'b1;
                        end
                    end else if (dir_q) begin
                        go_up = 1'b1;
                    end else begin
                        go_dn = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (go_up) begin
            if (idx_q == LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (go_dn) begin
            if (idx_q == '0) begin
                idx_d  = LAST;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
        step_d = (idx_d != idx_q);
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            timer_q <= '0;
            mode_q  <= MODE_MANUAL;
        end else begin
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            timer_q <= timer_d;
            mode_q  <= bus.mode;
        end
    end

    assign bus.index = idx_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
    assign bus.dir   = dir_q;
endmodule

// File: doc/pic_sequencer.md
Name: pic_sequencer

Overview:
Parametrised picture-index sequencer for the VGA picture-ROM path. Drives the ROM picture index from the debounced next/prev buttons. Also has three timed slideshow modes: forward, reverse and ping-pong. Adds edge-triggered stepping, hold-to-repeat, pause, and step/wrap strobes for the overlay and LED logic.

Parameters:
TOTAL_PIC, 13, number of pictures; legal 1..2^IDX_W
IDX_W, 4, index width
AUTO_PERIOD, 16777216, vgaclk cycles per slideshow step (0.67 s at 25 MHz)
HOLD_CYC, 12500000, cycles a button must stay held before auto-repeat starts
REP_CYC, 5000000, cycles between repeat steps while a button is held

Ports:
vgaclk  in  1  pixel clock; the only clock
rst  in  1  asynchronous, active-high reset
btn_next  in  1  debounced level; step forward
btn_prev  in  1  debounced level; step backward
mode  in  2  00 manual, 01 slideshow forward, 10 slideshow reverse, 11 ping-pong
pause  in  1  freezes the slideshow timer; buttons still act
index  out  IDX_W  current picture, 0..TOTAL_PIC-1
step  out  1  one-cycle pulse on every index change
wrap  out  1  one-cycle pulse when index wraps (last->0 or 0->last) or ping-pong reverses
dir  out  1  ping-pong direction, 1 = up

Behaviour:
- Reset (async assert; release sampled on vgaclk):
  - index=0, step=0, wrap=0, dir=1
  - timer, hold and repeat counters = 0
  - button history regs = 0
- All outputs are registered. index updates on the edge after the qualifying event; step and wrap pulse in that same cycle.
- inc: index==TOTAL_PIC-1 -> 0 with wrap=1, else index+1.
- dec: index==0 -> TOTAL_PIC-1 with wrap=1, else index-1.
- Button events, active in every mode:
  - Rising edge of btn_next gives an inc; rising edge of btn_prev gives a dec.
  - Held level alone does nothing until the hold counter reaches HOLD_CYC-1. Then one step fires, and a further step every REP_CYC cycles while the button stays held.
  - Release clears the hold and repeat counters.
  - Both buttons high, or both rising in the same cycle: no step, both hold counters cleared.
  - A button step restarts the slideshow timer from 0.
- Slideshow timer:
  - Counts when mode!=00 and pause=0.
  - When the count reaches AUTO_PERIOD-1 it resets to 0 and one auto step fires.
  - Mode 01 auto step = inc; mode 10 = dec.
  - Mode 11 auto step:
    - dir=1 and index==TOTAL_PIC-1: dir<=0, index<=index-1, wrap=1.
    - dir=0 and index==0: dir<=1, index<=1, wrap=1.
    - Otherwise step in direction dir.
  - Mode 00: timer held at 0.
- Any change of mode clears the timer in the cycle it is seen. dir is not altered.
- pause=1 freezes the timer value; it resumes from the same count when pause falls.
- Priority: a button step and an auto step in the same cycle -> the button step wins and the auto step is dropped.
- TOTAL_PIC==1: index stays 0. No step pulses. wrap still pulses on events that would wrap. Ping-pong does not toggle dir.
- Counter widths come from $clog2 of the respective parameter, minimum 1.
- Reset asserted mid-count or mid-hold aborts immediately; no pulse is emitted on release.

Decomposition:
- Shared package pic_pkg:
  - mode encodings MODE_MANUAL, MODE_FWD, MODE_REV, MODE_PING
  - default TOTAL_PIC
  - clog2 helper
- One sub-module, btn_repeat: edge detect plus hold/repeat counter. Emits a one-cycle fire pulse. Instantiated twice, for next and prev.
- The top level holds the index/dir register, the timer and the arbitration.

Test Plan:
Simulation parameters: TOTAL_PIC=5, AUTO_PERIOD=8, HOLD_CYC=6, REP_CYC=3.
- rst mid-operation with index=3 -> index=0, dir=1, no step pulse after release; btn_next held 3 cycles from 0 -> index=1 exactly once, step high 1 cycle.
- Manual wrap: index=4, btn_next edge -> index=0, wrap=1; index=0, btn_prev edge -> index=4, wrap=1.
- Hold repeat: btn_next held 15 cycles from index 0 -> edge step to 1, then repeat steps at hold cycles 6, 9, 12 -> index=4; release -> no further steps.
- Mode 11 from index 0 for 64 cycles -> index sequence 1,2,3,4,3,2,1,0,... one step per 8 cycles; wrap at 4->3 and 0->1; dir toggles at the same times.
- Mode 01 with pause=1 for 20 cycles mid-count -> index unchanged; after pause falls the step lands 8 cycles from the count's original start plus the paused time.
- Both buttons rise in the same cycle in mode 00 -> index unchanged, step=0. btn_prev edge coinciding with the timer's terminal count in mode 01 -> net index-1 and the timer restarts at 0.
